// File: rtl/io_bus_pkg.sv
// Shared state encodings and constants for the CPU-side IO bus controller.
package io_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } bus_state_t;

  // Returned to the CPU on unmapped or timed-out reads; sliced to DSIZE by users.
  localparam logic [63:0] RD_ERR_DATA = '1;

  function automatic int slot_bits(input int nslots);
    return (nslots <= 2) ? 1 : $clog2(nslots);
  endfunction

endpackage

// File: rtl/io_wait_timer.sv
// Wait-state counter for IO transfers; 'last' flags the final permitted WAIT cycle.
module io_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_b,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Holds at the terminal value so the counter never wraps.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && !last)
      count <= count + CW'(1);
  end

  assign last = (count == LAST_CNT);

endmodule

// File: rtl/io_bus_ctrl.sv
// CPU-side bus controller: zero-wait RAM decode plus NSLOTS handshaked IO slots
// with stall, timeout abort and a sticky bus error.
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter int DSIZE    = 16,
  parameter int ASIZE    = 16,
  parameter int NSLOTS   = 4,
  parameter int SLOT_LSB = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic [ASIZE-1:0]      address,
  input  logic                  rnw,
  input  logic                  vpa,
  input  logic                  vda,
  input  logic                  vio,
  output logic [DSIZE-1:0]      cpu_din,
  output logic                  cpu_clken,
  output logic                  ram_cs_b,
  input  logic [DSIZE-1:0]      ram_dout,
  output logic [NSLOTS-1:0]     io_cs_b,
  input  logic [NSLOTS*16-1:0]  io_dout,
  input  logic [NSLOTS-1:0]     io_rdy,
  input  logic                  err_clr,
  output logic                  bus_err,
  output logic [ASIZE-1:0]      err_addr
);

  localparam int SLOT_BITS = slot_bits(NSLOTS);
  localparam int SW1 = SLOT_BITS + 1;
  localparam logic [SLOT_BITS:0] NSLOTS_W = SW1'(NSLOTS);
  localparam logic [DSIZE-1:0] RD_ERR = RD_ERR_DATA[DSIZE-1:0];

  bus_state_t           state;
  logic [SLOT_BITS-1:0] slot_dec;
  logic [SLOT_BITS-1:0] slot_q;
  logic [SLOT_BITS-1:0] sel_slot;
  logic                 slot_ok;
  logic                 io_req;
  logic                 mem_req;
  logic                 sel_active;
  logic                 rdy_sel;
  logic [15:0]          dout_sel;
  logic [DSIZE-1:0]     rdata;
  logic                 tmr_clr;
  logic                 tmr_en;
  logic                 tmr_last;
  logic                 err_set;
  logic                 unused_rnw;

  // Write data bypasses this block, so direction plays no part in the handshake.
  assign unused_rnw = rnw;

  assign slot_dec = address[SLOT_LSB +: SLOT_BITS];
  assign slot_ok  = ({1'b0, slot_dec} < NSLOTS_W);
  assign io_req   = vio & reset_b;
  assign mem_req  = ~vio & (vpa | vda);

  always_comb begin
    sel_active = 1'b0;
    sel_slot   = slot_q;
    case (state)
      ST_IDLE: begin
        sel_active = io_req & slot_ok;
        sel_slot   = slot_dec;
      end
      ST_WAIT: sel_active = 1'b1;
      default: sel_active = 1'b0;
    endcase
  end

  always_comb begin
    io_cs_b = '1;
    if (sel_active) begin
      for (int k = 0; k < NSLOTS; k++)
        if (sel_slot == SLOT_BITS'(k))
          io_cs_b[k] = 1'b0;
    end
  end

  always_comb begin
    rdy_sel  = 1'b0;
    dout_sel = '0;
    for (int k = 0; k < NSLOTS; k++) begin
      if (slot_q == SLOT_BITS'(k)) begin
        rdy_sel  = io_rdy[k];
        dout_sel = io_dout[16*k +: 16];
      end
    end
  end

  assign tmr_clr = (state == ST_IDLE);
  assign tmr_en  = (state == ST_WAIT) & ~rdy_sel;
  assign err_set = ((state == ST_IDLE) & io_req & ~slot_ok) |
                   ((state == ST_WAIT) & ~rdy_sel & tmr_last);

  io_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset_b (reset_b),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .last    (tmr_last)
  );

  assign cpu_clken = (state == ST_IDLE) ? ~io_req : (state == ST_DONE);
  assign ram_cs_b  = ~((state == ST_IDLE) & mem_req);
  assign cpu_din   = (state == ST_DONE) ? rdata : ram_dout;

  // A same-cycle error set takes priority over err_clr.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state    <= ST_IDLE;
      slot_q   <= '0;
      rdata    <= '0;
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io_req) begin
            slot_q <= slot_dec;
            if (slot_ok) begin
              state <= ST_WAIT;
            end else begin
              rdata <= RD_ERR;
              state <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (rdy_sel) begin
            rdata <= DSIZE'(dout_sel);
            state <= ST_DONE;
          end else if (tmr_last) begin
            rdata <= RD_ERR;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (err_set) begin
        bus_err  <= 1'b1;
        err_addr <= address;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

endmodule
